execute_stage: RTL and testbench

- Pipeline EX stage; sits directly upstream of the memory stage.
- Takes decoded operands and the ALU op from the ID/EX boundary and computes the result.
- Registers the XM_RD, ALUout and XM_RegWrite bundle that the memory stage consumes.
- Contains an iterative shift-add multiplier. While it runs, the stage stalls upstream and sends bubbles downstream.

---
 rtl/exec_pkg.sv | 45 ++++
 rtl/exec_mul_iter.sv | 91 +++++++++
 rtl/execute_stage.sv | 108 ++++++++++
 tb/tb_execute_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU op codes, multiplier FSM
// encoding and the EX->MEM payload bundle.
package exec_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 4;

  // ALU operation codes presented on DX_ALUctr
  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [OP_W-1:0] ALU_SLT = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLL = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRL = 4'd7;
  localparam logic [OP_W-1:0] ALU_SRA = 4'd8;
  localparam logic [OP_W-1:0] ALU_MUL = 4'd9;
  localparam logic [OP_W-1:0] ALU_NOP = 4'd15;

  // Multiplier FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Payload handed to the memory stage
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu;
    logic              we;
  } xm_bundle_t;

  // Build a bundle; a non-writing instruction always carries rd=0
  function automatic xm_bundle_t make_xm(input logic              we,
                                         input logic [REG_AW-1:0] rd,
                                         input logic [XLEN-1:0]   res);
    xm_bundle_t b;
    b.we  = we;
    b.rd  = we ? rd : '0;
    b.alu = res;
    return b;
  endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: retires MUL_BITS_PER_CYCLE multiplier bits
// per busy cycle and holds the low XLEN bits of the product in DONE.
module exec_mul_iter
  import exec_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int unsigned MUL_ITERS = XLEN / MUL_BITS_PER_CYCLE;
  localparam int unsigned CNT_W     = 5;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  partial;

  // Partial product of the multiplicand with the low chunk of the multiplier
  always_comb begin
    partial = '0;
    for (int unsigned j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
  end

  // Next-state logic: load on start, shift-accumulate while busy, abort anywhere
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = acc_q + partial;
          mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
          mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MUL_ITERS - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign busy    = (state_q == ST_BUSY);
  assign done    = (state_q == ST_DONE);
  assign product = acc_q;

endmodule

// File: rtl/execute_stage.sv
// Pipeline EX stage: single-cycle ALU, iterative multiplier, EX/MEM registers
// and upstream stall generation.
module execute_stage
  import exec_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   DX_ALUctr,
  input  logic [XLEN-1:0]   DX_A,
  input  logic [XLEN-1:0]   DX_B,
  input  logic [REG_AW-1:0] DX_RD,
  input  logic              DX_RegWrite,
  input  logic              flush,
  output logic              stall,
  output logic [REG_AW-1:0] XM_RD,
  output logic [XLEN-1:0]   ALUout,
  output logic              XM_RegWrite
);

  logic              is_mul;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic              mul_idle;
  logic [XLEN-1:0]   mul_product;
  logic [REG_AW-1:0] mul_rd_q;
  logic              mul_we_q;
  logic [XLEN-1:0]   alu_res;
  logic              alu_ok;
  logic [4:0]        shamt;
  xm_bundle_t        xm_d, xm_q;

  assign is_mul    = (DX_ALUctr == ALU_MUL);
  assign mul_idle  = !mul_busy && !mul_done;
  assign mul_start = mul_idle && is_mul && !flush;
  assign shamt     = DX_B[4:0];

  // Upstream holds while a multiply is being accepted or is in progress
  assign stall = rst && ((mul_idle && is_mul && !flush) || mul_busy);

  exec_mul_iter #(
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .abort  (flush),
    .a      (DX_A),
    .b      (DX_B),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  // Single-cycle ALU; NOP, MUL and undefined codes produce no result
  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (DX_ALUctr)
      ALU_ADD: alu_res = DX_A + DX_B;
      ALU_SUB: alu_res = DX_A - DX_B;
      ALU_AND: alu_res = DX_A & DX_B;
      ALU_OR:  alu_res = DX_A | DX_B;
      ALU_XOR: alu_res = DX_A ^ DX_B;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(DX_A) < $signed(DX_B))};
      ALU_SLL: alu_res = DX_A << shamt;
      ALU_SRL: alu_res = DX_A >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(DX_A) >>> shamt);
      default: alu_ok  = 1'b0;
    endcase
  end

  // Select the bundle for the memory stage; flush beats every other source
  always_comb begin
    xm_d = '0;
    if (flush) begin
      xm_d = '0;
    end else if (mul_done) begin
      xm_d = make_xm(mul_we_q, mul_rd_q, mul_product);
    end else if (mul_idle && alu_ok) begin
      xm_d = make_xm(DX_RegWrite, DX_RD, alu_res);
    end
  end

  // Capture the multiply's destination when it is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_rd_q <= '0;
      mul_we_q <= 1'b0;
    end else if (mul_start) begin
      mul_rd_q <= DX_RD;
      mul_we_q <= DX_RegWrite;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) xm_q <= '0;
    else      xm_q <= xm_d;
  end

  assign XM_RD       = xm_q.rd;
  assign ALUout      = xm_q.alu;
  assign XM_RegWrite = xm_q.we;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus random instruction stream
// compared cycle by cycle against a behavioural model of the stage.
module tb_execute_stage;

  localparam int unsigned MUL_ITERS = 32;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_NOP = 4'd15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  DX_ALUctr = OP_MUL;
  logic [31:0] DX_A = '0;
  logic [31:0] DX_B = '0;
  logic [4:0]  DX_RD = '0;
  logic        DX_RegWrite = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [4:0]  XM_RD;
  logic [31:0] ALUout;
  logic        XM_RegWrite;

  execute_stage #(.MUL_BITS_PER_CYCLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .DX_ALUctr  (DX_ALUctr),
    .DX_A       (DX_A),
    .DX_B       (DX_B),
    .DX_RD      (DX_RD),
    .DX_RegWrite(DX_RegWrite),
    .flush      (flush),
    .stall      (stall),
    .XM_RD      (XM_RD),
    .ALUout     (ALUout),
    .XM_RegWrite(XM_RegWrite)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: edges left until the multiply writes back (0 = none pending)
  int          mul_left = 0;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;
  logic        m_we;
  logic        e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_alu;
  logic        e_stall;
  logic        last_stall = 1'b0;
  logic        last_flush = 1'b0;
  logic        obs_stall  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_alu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r);
    int         sa, sb, sh;
    logic [63:0] ext;
    sa = a;
    sb = b;
    sh = int'(b[4:0]);
    r  = '0;
    ref_alu = 1'b1;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = a << sh;
      4'd7: r = a >> sh;
      4'd8: begin ext = {{32{a[31]}}, a}; r = 32'(ext >> sh); end
      default: ref_alu = 1'b0;
    endcase
  endfunction

  task automatic set_out(input logic we, input logic [4:0] rd, input logic [31:0] alu);
    e_we  = we;
    e_rd  = we ? rd : 5'd0;
    e_alu = alu;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic we, input logic fl);
    DX_ALUctr   = op;
    DX_A        = a;
    DX_B        = b;
    DX_RD       = rd;
    DX_RegWrite = we;
    flush       = fl;
  endtask

  // One clock cycle: check stall, advance the model, check registered outputs
  task automatic step();
    logic [31:0] r;
    logic        ok;
    #1;
    e_stall = rst && ((mul_left == 0 && DX_ALUctr == OP_MUL && !flush) || mul_left > 1);
    obs_stall = stall;
    chk("stall", 32'(stall), 32'(e_stall));
    set_out(1'b0, 5'd0, 32'd0);
    if (flush) begin
      mul_left = 0;
    end else if (mul_left > 1) begin
      mul_left--;
    end else if (mul_left == 1) begin
      set_out(m_we, m_rd, m_a * m_b);
      mul_left = 0;
    end else if (DX_ALUctr == OP_MUL) begin
      m_a = DX_A; m_b = DX_B; m_rd = DX_RD; m_we = DX_RegWrite;
      mul_left = MUL_ITERS + 1;
    end else begin
      ok = ref_alu(DX_ALUctr, DX_A, DX_B, r);
      if (ok) set_out(DX_RegWrite, DX_RD, r);
    end
    last_stall = e_stall;
    last_flush = flush;
    @(posedge clk);
    #1;
    chk("XM_RegWrite", 32'(XM_RegWrite), 32'(e_we));
    chk("XM_RD", 32'(XM_RD), 32'(e_rd));
    chk("ALUout", ALUout, e_alu);
  endtask

  // Present a multiply and step until the stage stops stalling (write-back cycle)
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output int n_stall);
    drive(OP_MUL, a, b, rd, 1'b1, 1'b0);
    n_stall = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!obs_stall) break;
      n_stall++;
    end
    chk("mul_stall_cycles", 32'(n_stall), 32'd33);
  endtask

  // Assert reset between clock edges and confirm outputs clear immediately
  task automatic reset_pulse();
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async_stall", 32'(stall), 32'd0);
    chk("rst_async_we", 32'(XM_RegWrite), 32'd0);
    chk("rst_async_rd", 32'(XM_RD), 32'd0);
    chk("rst_async_alu", ALUout, 32'd0);
    mul_left = 0;
    set_out(1'b0, 5'd0, 32'd0);
    last_stall = 1'b0;
    last_flush = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_alu", ALUout, 32'd0);
    chk("rst_hold_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_instr();
    int          k;
    logic [3:0]  op;
    logic [31:0] a, b;
    k = $urandom_range(0, 19);
    if (k < 2)       op = OP_MUL;
    else if (k == 2) op = 4'($urandom_range(10, 15));
    else             op = 4'($urandom_range(0, 8));
    a = $urandom;
    b = $urandom;
    if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
    if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
    drive(op, a, b, 5'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset state, with a MUL already on DX to show stall stays low in reset
    #2;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_we", 32'(XM_RegWrite), 32'd0);
    chk("reset_rd", 32'(XM_RD), 32'd0);
    chk("reset_alu", ALUout, 32'd0);
    @(negedge clk);
    @(negedge clk);
    drive(OP_NOP, 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b1;

    // ADD wraps into the sign bit, no stall
    drive(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b0);
    step();
    chk("add_alu", ALUout, 32'h8000_0000);
    chk("add_rd", 32'(XM_RD), 32'd3);
    chk("add_stall", 32'(obs_stall), 32'd0);

    // SLT signed and SRA sign fill
    drive(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 1'b0);
    step();
    chk("slt_alu", ALUout, 32'd1);
    drive(OP_SRA, 32'h8000_0000, 32'd4, 5'd4, 1'b1, 1'b0);
    step();
    chk("sra_alu", ALUout, 32'hF800_0000);

    // Multiply then a following ADD one cycle later
    run_mul(32'h0001_0001, 32'h0001_0001, 5'd5, n);
    chk("mul_alu", ALUout, 32'h0002_0001);
    chk("mul_rd", 32'(XM_RD), 32'd5);
    chk("mul_we", 32'(XM_RegWrite), 32'd1);
    drive(OP_ADD, 32'd10, 32'd20, 5'd6, 1'b1, 1'b0);
    step();
    chk("post_mul_add", ALUout, 32'd30);

    // Flush at busy count 10 discards the product
    drive(OP_MUL, 32'd3, 32'd4, 5'd7, 1'b1, 1'b0);
    step();
    repeat (10) step();
    flush = 1'b1;
    step();
    chk("flush_we", 32'(XM_RegWrite), 32'd0);
    drive(OP_ADD, 32'd20, 32'd22, 5'd8, 1'b1, 1'b0);
    step();
    chk("flush_stall_drop", 32'(obs_stall), 32'd0);
    drive(OP_NOP, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) begin
      step();
      chk("flush_no_product", 32'(ALUout == 32'd12), 32'd0);
    end

    // Async reset while busy, then a fresh multiply
    drive(OP_MUL, 32'd5, 32'd7, 5'd9, 1'b1, 1'b0);
    step();
    repeat (3) step();
    reset_pulse();
    run_mul(32'hFFFF_FFFF, 32'd2, 5'd9, n);
    chk("mul2_alu", ALUout, 32'hFFFF_FFFE);

    // Async reset with a live result in the EX/MEM register
    drive(OP_ADD, 32'd1, 32'd2, 5'd4, 1'b1, 1'b0);
    step();
    drive(OP_NOP, 0, 0, 0, 1'b0, 1'b0);
    reset_pulse();

    // NOP and undefined codes are bubbles even with RegWrite set
    drive(OP_NOP, 32'd1, 32'd2, 5'd6, 1'b1, 1'b0);
    step();
    chk("nop_we", 32'(XM_RegWrite), 32'd0);
    chk("nop_alu", ALUout, 32'd0);
    drive(4'd12, 32'd1, 32'd2, 5'd6, 1'b1, 1'b0);
    step();
    chk("undef_rd", 32'(XM_RD), 32'd0);
    chk("undef_we", 32'(XM_RegWrite), 32'd0);

    // Random stream; upstream holds DX while stalled unless it was flushed
    for (int i = 0; i < 800; i++) begin
      if (!(last_stall && !last_flush)) rand_instr();
      flush = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
